// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared definitions for the multicycle control unit: opcodes, ALU codes, FSM states and
// the decoded-instruction record passed from the opcode decoder to the sequencer.
package multicycle_ctrl_fsm_pkg;

  // Primary opcodes (Instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b100000;
  localparam logic [5:0] OP_ADDI  = 6'b110000;
  localparam logic [5:0] OP_LI    = 6'b111000;
  localparam logic [5:0] OP_LUI   = 6'b111001;
  localparam logic [5:0] OP_ANDI  = 6'b110010;
  localparam logic [5:0] OP_ORI   = 6'b110011;
  localparam logic [5:0] OP_LB    = 6'b000011;
  localparam logic [5:0] OP_LW    = 6'b001111;
  localparam logic [5:0] OP_SB    = 6'b000111;
  localparam logic [5:0] OP_SW    = 6'b011111;
  localparam logic [5:0] OP_B     = 6'b111111;
  localparam logic [5:0] OP_BEQ   = 6'b000000;
  localparam logic [5:0] OP_BNE   = 6'b000001;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;

  typedef enum logic [2:0] {
    StIfetch,
    StDecode,
    StExec,
    StMem,
    StWb
  } state_e;

  typedef enum logic [2:0] {
    ClsRtype,
    ClsImm,
    ClsLoad,
    ClsStore,
    ClsBranch,
    ClsIllegal
  } op_class_e;

  // Branch condition: unconditional, taken on Zero, taken on !Zero
  typedef enum logic [1:0] {
    BrAlways,
    BrEq,
    BrNe
  } br_kind_e;

  typedef struct packed {
    op_class_e cls;
    logic [3:0] alu_func;
    logic       byte_op;
    br_kind_e   br_kind;
  } dec_t;

  localparam dec_t DecIllegal = '{
    cls:      ClsIllegal,
    alu_func: ALU_ADD,
    byte_op:  1'b0,
    br_kind:  BrAlways
  };

endpackage

// File: rtl/ctrl_opcode_decoder.sv
// Combinational opcode classifier: maps the primary opcode to an instruction class plus the
// ALU operation, byte-access flag and branch condition that go with it.
module ctrl_opcode_decoder
  import multicycle_ctrl_fsm_pkg::*;
(
  input  logic [5:0] opcode_i,
  output dec_t       dec_o
);

  // Opcode lookup; anything not listed is reported as illegal
  always_comb begin
    dec_o = DecIllegal;
    case (opcode_i)
      OP_RTYPE: dec_o.cls = ClsRtype;
      OP_ADDI, OP_LI, OP_LUI: begin
        dec_o.cls      = ClsImm;
        dec_o.alu_func = ALU_ADD;
      end
      OP_ANDI: begin
        dec_o.cls      = ClsImm;
        dec_o.alu_func = ALU_AND;
      end
      OP_ORI: begin
        dec_o.cls      = ClsImm;
        dec_o.alu_func = ALU_OR;
      end
      OP_LB: begin
        dec_o.cls     = ClsLoad;
        dec_o.byte_op = 1'b1;
      end
      OP_LW: dec_o.cls = ClsLoad;
      OP_SB: begin
        dec_o.cls     = ClsStore;
        dec_o.byte_op = 1'b1;
      end
      OP_SW: dec_o.cls = ClsStore;
      OP_B: begin
        dec_o.cls     = ClsBranch;
        dec_o.br_kind = BrAlways;
      end
      OP_BEQ: begin
        dec_o.cls      = ClsBranch;
        dec_o.alu_func = ALU_SUB;
        dec_o.br_kind  = BrEq;
      end
      OP_BNE: begin
        dec_o.cls      = ClsBranch;
        dec_o.alu_func = ALU_SUB;
        dec_o.br_kind  = BrNe;
      end
      default: dec_o = DecIllegal;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle control sequencer: IFETCH/DECODE/EXEC/MEM/WB with a shared memory-wait timeout.
// Decoded opcode class and Func are captured in DECODE so later Instr changes are harmless.
module multicycle_ctrl_fsm
  import multicycle_ctrl_fsm_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Instr,
  input  logic        Zero,
  input  logic        Mem_Ready,
  output logic        IR_LdEn,
  output logic        PC_LdEn,
  output logic        PC_sel,
  output logic        RF_WrEn,
  output logic        RF_B_sel,
  output logic        RF_WrData_sel,
  output logic        ALU_Bin_sel,
  output logic [3:0]  ALU_func,
  output logic        Mem_Req,
  output logic        Mem_WrEn,
  output logic        ByteOp,
  output logic        Illegal
);

  localparam int unsigned CntW = $clog2(MEM_TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(MEM_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  dec_t            dec_q, dec_d;
  logic [3:0]      func_q, func_d;
  // High for the one cycle after Reset is sampled: outputs forced idle, no transitions
  logic            boot_q, boot_d;

  dec_t dec;
  logic mem_timeout;

  // Func bits above [3:0] and the register fields are consumed by the datapath, not here
  logic unused_instr;
  assign unused_instr = ^Instr[25:4];

  ctrl_opcode_decoder u_decoder (
    .opcode_i (Instr[31:26]),
    .dec_o    (dec)
  );

  // Final wait cycle of an IFETCH/MEM access with no completion
  assign mem_timeout = (cnt_q == CntLast) && !Mem_Ready;

  // State, timeout counter and latched instruction fields
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StIfetch;
      cnt_q   <= '0;
      dec_q   <= DecIllegal;
      func_q  <= '0;
      boot_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
      func_q  <= func_d;
      boot_q  <= boot_d;
    end
  end

  // Next state; counter defaults to 0 so every state entry (or re-entry) clears it
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    dec_d   = dec_q;
    func_d  = func_q;
    boot_d  = 1'b0;
    if (!boot_q) begin
      unique case (state_q)
        StIfetch: begin
          if (Mem_Ready) begin
            state_d = StDecode;
          end else if (mem_timeout) begin
            state_d = StIfetch;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StDecode: begin
          dec_d   = dec;
          func_d  = Instr[3:0];
          state_d = (dec.cls == ClsIllegal) ? StIfetch : StExec;
        end
        StExec: begin
          case (dec_q.cls)
            ClsRtype, ClsImm:  state_d = StWb;
            ClsLoad, ClsStore: state_d = StMem;
            default:           state_d = StIfetch;
          endcase
        end
        StMem: begin
          if (Mem_Ready) begin
            state_d = (dec_q.cls == ClsLoad) ? StWb : StIfetch;
          end else if (mem_timeout) begin
            state_d = StIfetch;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StWb:    state_d = StIfetch;
        default: state_d = StIfetch;
      endcase
    end
  end

  // Control word for the current state; only PC_LdEn in EXEC looks at Zero
  always_comb begin
    IR_LdEn       = 1'b0;
    PC_LdEn       = 1'b0;
    PC_sel        = 1'b0;
    RF_WrEn       = 1'b0;
    RF_B_sel      = 1'b0;
    RF_WrData_sel = 1'b0;
    ALU_Bin_sel   = 1'b0;
    ALU_func      = ALU_ADD;
    Mem_Req       = 1'b0;
    Mem_WrEn      = 1'b0;
    ByteOp        = 1'b0;
    Illegal       = 1'b0;
    if (!boot_q) begin
      unique case (state_q)
        StIfetch: begin
          Mem_Req = 1'b1;
          if (Mem_Ready) begin
            IR_LdEn = 1'b1;
            PC_LdEn = 1'b1;
          end else begin
            Illegal = mem_timeout;
          end
        end
        StDecode: Illegal = (dec.cls == ClsIllegal);
        StExec: begin
          case (dec_q.cls)
            ClsRtype: ALU_func = func_q;
            ClsImm: begin
              ALU_Bin_sel = 1'b1;
              ALU_func    = dec_q.alu_func;
            end
            ClsLoad, ClsStore: begin
              ALU_Bin_sel = 1'b1;
              ALU_func    = ALU_ADD;
            end
            ClsBranch: begin
              ALU_func = dec_q.alu_func;
              PC_sel   = 1'b1;
              case (dec_q.br_kind)
                BrEq:    PC_LdEn = Zero;
                BrNe:    PC_LdEn = !Zero;
                default: PC_LdEn = 1'b1;
              endcase
            end
            default: ;
          endcase
        end
        StMem: begin
          Mem_Req  = 1'b1;
          Mem_WrEn = (dec_q.cls == ClsStore);
          RF_B_sel = (dec_q.cls == ClsStore);
          ByteOp   = dec_q.byte_op;
          Illegal  = mem_timeout;
        end
        StWb: begin
          RF_WrEn       = 1'b1;
          RF_WrData_sel = (dec_q.cls == ClsLoad);
        end
        default: ;
      endcase
    end
  end

endmodule
